// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths and FSM state type for the MAC sequencer
package mac_pkg;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 13;
  localparam int LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN1,
    DRAIN2,
    DONE
  } seq_state_t;
endpackage

// File: rtl/mac_len_counter.sv
// rtl/mac_len_counter.sv - job beat counter; flags the final operand pair of a job
module mac_len_counter #(
  parameter int LEN_W = mac_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             inc_i,
  output logic             last_o
);
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      len_q <= len_i;
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Only consulted during RUN, where len_q is guaranteed non-zero.
  assign last_o = (cnt_q == (len_q - 1'b1));
endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - drives one MAC through clear/accumulate/drain and returns the sum
module mac_sequencer #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ACC_W  = mac_pkg::ACC_W,
  parameter int LEN_W  = mac_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_en,
  output logic              mac_clr,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf
);
  import mac_pkg::*;

  seq_state_t        state_q;
  logic [DATA_W-1:0] mac_a_q, mac_b_q;
  logic              mac_en_q, mac_clr_q;
  logic              res_valid_q, res_ovf_q;
  logic [ACC_W-1:0]  res_data_q;
  logic [ACC_W-1:0]  acc_prev_q;
  logic              en_d_q;
  logic              accept, load, last_beat, wrapped;

  assign accept = (state_q == RUN) && in_valid;
  assign load   = (state_q == IDLE) && start && (len != '0);

  mac_len_counter #(.LEN_W(LEN_W)) u_len_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .len_i  (len),
    .inc_i  (accept),
    .last_o (last_beat)
  );

  // A single step adds less than 2**ACC_W, so any wrap shows up as a decrease.
  assign wrapped = en_d_q && (mac_acc < acc_prev_q)
                   && (state_q != IDLE) && (state_q != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_data_q  <= '0;
      acc_prev_q  <= '0;
      en_d_q      <= 1'b0;
    end else begin
      acc_prev_q <= mac_acc;
      en_d_q     <= mac_en_q;
      mac_clr_q  <= 1'b0;
      if (wrapped) res_ovf_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            res_ovf_q <= 1'b0;
            if (len != '0) begin
              mac_clr_q <= 1'b1;
              state_q   <= CLEAR;
            end else begin
              res_data_q  <= '0;
              res_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        CLEAR: state_q <= RUN;
        RUN: begin
          if (in_valid) begin
            mac_a_q  <= in_a;
            mac_b_q  <= in_b;
            mac_en_q <= 1'b1;
            if (last_beat) state_q <= DRAIN1;
          end else begin
            mac_en_q <= 1'b0;
          end
        end
        DRAIN1: begin
          mac_en_q <= 1'b0;
          state_q  <= DRAIN2;
        end
        DRAIN2: begin
          res_data_q  <= mac_acc;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == RUN);
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - self-checking bench for mac_sequencer driving a mac2-style accumulator
module tb_mac_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0, in_b = '0;
  logic [7:0]  mac_a, mac_b;
  logic        mac_en, mac_clr;
  logic [12:0] mac_acc = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [12:0] res_data;
  logic        res_ovf;

  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  int          clr_cnt = 0;
  int          en_cnt = 0;
  logic [12:0] exp_data = '0;
  logic        exp_ovf = 1'b0;
  logic [7:0]  pa [256];
  logic [7:0]  pb [256];
  logic [12:0] got_data;
  logic        got_ovf;

  always #5 clk = ~clk;

  mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf)
  );

  // mac2: sync clear, accumulates the upper byte of the 8x8 product
  always @(posedge clk) begin
    if (mac_clr) mac_acc <= '0;
    else if (mac_en) mac_acc <= mac_acc + 13'((16'(mac_a) * 16'(mac_b)) >> 8);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (mac_clr) clr_cnt++;
      if (mac_en) en_cnt++;
      if (res_valid) begin
        check("res_data", res_data, exp_data);
        check("res_ovf", res_ovf, exp_ovf);
      end
      if (in_ready) check("in_ready_busy", busy, 1);
    end
  end

  task automatic run_job(input int L, input int max_gap, input int rdy_delay, input bit poke_start,
                         output logic [12:0] d, output logic o);
    int raw;
    int n;
    raw = 0;
    for (int i = 0; i < L; i++) raw += (int'(pa[i]) * int'(pb[i])) / 256;
    @(negedge clk);
    exp_data = 13'(raw % 8192);
    exp_ovf  = (raw >= 8192);
    clr_cnt = 0;
    en_cnt = 0;
    check("idle_busy", busy, 0);
    start = 1'b1;
    len = 8'(L);
    @(posedge clk); #1;
    start = 1'b0;
    len = 8'($urandom);
    if (L == 0) begin
      check("len0_done_next_edge", res_valid, 1);
    end else begin
      check("clear_entry_busy", busy, 1);
      for (int i = 0; i < L; i++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_a = pa[i];
        in_b = pb[i];
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
          check("in_ready_timeout", in_ready, 1);
          i = L;
        end else begin
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b0;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      check("lat_edge0", res_valid, 0);
      @(posedge clk); #1;
      check("lat_edge1", res_valid, 0);
      @(posedge clk); #1;
      check("lat_edge2", res_valid, 1);
    end
    d = res_data;
    o = res_ovf;
    res_ready = 1'b0;
    repeat (rdy_delay) begin
      if (poke_start) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("done_hold", res_valid, 1);
    end
    start = poke_start;
    res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    res_ready = 1'b0;
    check("handshake_valid_low", res_valid, 0);
    check("handshake_start_ignored", busy, 0);
    check("mac_clr_cycles", clr_cnt, (L != 0) ? 1 : 0);
    check("mac_en_cycles", en_cnt, L);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {mac_en, mac_clr, res_valid, res_ovf}, 0);
    check("rst_data", {mac_a, mac_b, res_data}, 0);
    @(negedge clk); rst = 1'b0;
    mon_en = 1'b1;

    // T1
    pa[0] = 8'h80; pb[0] = 8'h80;
    pa[1] = 8'hFF; pb[1] = 8'hFF;
    pa[2] = 8'h10; pb[2] = 8'h10;
    run_job(3, 0, 0, 1'b0, got_data, got_ovf);
    check("t1_literal_data", got_data, 13'h13F);
    check("t1_literal_ovf", got_ovf, 0);

    // T3
    for (int i = 0; i < 40; i++) begin pa[i] = 8'hFF; pb[i] = 8'hFF; end
    run_job(40, 1, 1, 1'b0, got_data, got_ovf);
    check("t3_literal_data", got_data, 1968);
    check("t3_literal_ovf", got_ovf, 1);

    // T2 (res_ovf was left set by T3)
    run_job(0, 0, 2, 1'b1, got_data, got_ovf);
    check("t2_literal_data", got_data, 0);
    check("t2_literal_ovf", got_ovf, 0);

    // T4
    for (int i = 0; i < 4; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
    run_job(4, 3, 5, 1'b1, got_data, got_ovf);

    // T5: reset in RUN after two accepted beats
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'hC3; in_b = 8'hE7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_pre_rst_en", mac_en, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy_ready", {busy, in_ready}, 0);
    check("t5_rst_ctrl", {mac_en, mac_clr, res_valid, res_ovf}, 0);
    check("t5_rst_data", {mac_a, mac_b, res_data}, 0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    mon_en = 1'b1;
    pa[0] = 8'hFF; pb[0] = 8'h02;
    run_job(1, 0, 0, 1'b0, got_data, got_ovf);
    check("t5_literal_data", got_data, 13'h001);

    // T6 and randomized jobs; handshake-cycle start pokes, next job starts the following cycle
    for (int j = 0; j < 24; j++) begin
      int L;
      bit hot;
      hot = (j % 3 == 0);
      L = hot ? $urandom_range(30, 70) : $urandom_range(1, 20);
      for (int i = 0; i < L; i++) begin
        pa[i] = hot ? 8'($urandom_range(180, 255)) : 8'($urandom);
        pb[i] = hot ? 8'($urandom_range(180, 255)) : 8'($urandom);
      end
      run_job(L, $urandom_range(0, 3), $urandom_range(0, 4), 1'b1, got_data, got_ovf);
    end

    // maximum length
    for (int i = 0; i < 255; i++) begin pa[i] = 8'hFF; pb[i] = 8'hFF; end
    run_job(255, 0, 0, 1'b1, got_data, got_ovf);
    check("len255_literal_data", got_data, 7426);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
